rr_mux_reg: RTL and testbench

- Parametrised successor to the 16-bit two-input multiplexor: selects one of CHANNELS input streams of WIDTH bits onto a single registered output stream.
- Each input and the output use a valid/ready handshake.
- Two selection modes: fixed (external select) and round-robin (internal fair arbitration).
- Sits between multiple data producers (e.g. ALU result, memory read, I/O) and a single consumer in the Hack datapath.

---
 rtl/rr_mux_reg_if.sv | 28 ++
 rtl/rr_mux_reg.sv | 88 ++++++++
 tb/tb_rr_mux_reg.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rr_mux_reg_if.sv
// Handshake bundle for rr_mux_reg: select controls, CHANNELS input streams and one output stream.
// The slave modport is the mux; the master modport is the producers/consumer around it.
interface rr_mux_reg_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4
);
   localparam int SELW = $clog2(CHANNELS);

   logic                      mode;
   logic [SELW-1:0]           sel;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic [WIDTH-1:0]          out_data;
   logic [SELW-1:0]           out_chan;
   logic                      out_valid;
   logic                      out_ready;

   modport slave (
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );

   modport master (
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/rr_mux_reg.sv
// N-to-1 registered stream mux, fixed-select or round-robin; 1 cycle input-to-output latency.
// Backpressure: a stalled output register drops every in_ready; full rate when out_ready stays high.
module rr_mux_reg #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   rr_mux_reg_if.slave bus
);
   localparam int SELW = $clog2(CHANNELS);
   localparam logic [SELW:0]   NCH  = (SELW+1)'(CHANNELS);
   localparam logic [SELW-1:0] LAST = SELW'(CHANNELS-1);

   logic [SELW-1:0]     ptr;
   logic [SELW-1:0]     gnt;
   logic                gnt_vld;
   logic                load;
   logic [SELW:0]       idx;
   logic [CHANNELS-1:0] rdy;
   logic [WIDTH-1:0]    gnt_dat;

   logic [WIDTH-1:0]    out_data_q;
   logic [SELW-1:0]     out_chan_q;
   logic                out_valid_q;

   always_comb begin
      load    = ~out_valid_q | bus.out_ready;
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      rdy     = '0;
      gnt_dat = '0;

      if (bus.mode) begin
         // Search ptr, ptr+1, ... with wrap; the extra idx bit absorbs ptr+k overflow.
         for (int k = 0; k < CHANNELS; k++) begin
            idx = {1'b0, ptr} + k[SELW:0];
            if (idx >= NCH)
               idx = idx - NCH;
            if (!gnt_vld && bus.in_valid[idx[SELW-1:0]]) begin
               gnt_vld = 1'b1;
               gnt     = idx[SELW-1:0];
            end
         end
      end else if ({1'b0, bus.sel} < NCH && bus.in_valid[bus.sel]) begin
         gnt_vld = 1'b1;
         gnt     = bus.sel;
      end

      gnt_vld = gnt_vld & load;

      if (bus.mode) begin
         if (gnt_vld)
            rdy[gnt] = 1'b1;
      end else if ({1'b0, bus.sel} < NCH) begin
         rdy[bus.sel] = load;
      end

      for (int i = 0; i < CHANNELS; i++)
         if (gnt == SELW'(i))
            gnt_dat = bus.in_data[i*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         ptr         <= '0;
      end else begin
         if (gnt_vld) begin
            out_valid_q <= 1'b1;
            out_data_q  <= gnt_dat;
            out_chan_q  <= gnt;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (gnt_vld && bus.mode)
            ptr <= (gnt == LAST) ? '0 : gnt + 1'b1;
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_data  = out_data_q;
   assign bus.out_chan  = out_chan_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg (WIDTH=16, CHANNELS=4) with hand-computed expectations.
module tb_rr_mux_reg;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [15:0] chd [4];

   rr_mux_reg_if #(.WIDTH(16), .CHANNELS(4)) bus ();

   rr_mux_reg #(.WIDTH(16), .CHANNELS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_data();
      bus.in_data = {chd[3], chd[2], chd[1], chd[0]};
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [15:0] dat, input logic [1:0] chan);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_data"},  32'(bus.out_data),  32'(dat));
      check({tag, "_chan"},  32'(bus.out_chan),  32'(chan));
   endtask

   initial begin
      chd[0] = 16'h1000; chd[1] = 16'h1001; chd[2] = 16'h1002; chd[3] = 16'h1003;
      rst_n         = 1'b0;
      bus.mode      = 1'b1;
      bus.sel       = 2'd0;
      bus.in_valid  = 4'b1111;
      bus.out_ready = 1'b1;
      put_data();
      repeat (3) tick();
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data",  32'(bus.out_data),  32'h0);
      check("rst_chan",  32'(bus.out_chan),  32'd0);

      // Round-robin fairness from ptr=0 with all channels requesting.
      rst_n = 1'b1;
      #1;
      check("rr_rdy0", 32'(bus.in_ready), 32'b0001);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_out("rr_seq", chd[i % 4], 2'(i % 4));
      end

      // Grant ch2 (ptr=2 -> 3), then skip/wrap over 0101.
      tick();
      chk_out("rr_ch2", chd[2], 2'd2);
      bus.in_valid = 4'b0101;
      #1;
      check("wrap_rdy", 32'(bus.in_ready), 32'b0001);
      tick(); chk_out("wrap_a", chd[0], 2'd0);
      check("wrap_rdy2", 32'(bus.in_ready), 32'b0100);
      tick(); chk_out("wrap_b", chd[2], 2'd2);
      tick(); chk_out("wrap_c", chd[0], 2'd0);

      // Backpressure holding 0x00AA on ch2; ptr=3 must survive the stall.
      chd[2] = 16'h00AA;
      put_data();
      tick(); chk_out("bp_load", 16'h00AA, 2'd2);
      bus.out_ready = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         check("bp_rdy", 32'(bus.in_ready), 32'b0000);
         tick();
         chk_out("bp_hold", 16'h00AA, 2'd2);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_rel_rdy", 32'(bus.in_ready), 32'b0001);
      tick(); chk_out("bp_next", chd[0], 2'd0);

      // Load ch1 (ptr 1 -> 2), stall, switch to fixed sel=3.
      bus.in_valid = 4'b0010;
      #1;
      tick(); chk_out("ms_ch1", chd[1], 2'd1);
      bus.out_ready = 1'b0;
      bus.in_valid  = 4'b1111;
      bus.mode      = 1'b0;
      bus.sel       = 2'd3;
      #1;
      check("ms_stall_rdy", 32'(bus.in_ready), 32'b0000);
      tick(); chk_out("ms_held", chd[1], 2'd1);
      bus.out_ready = 1'b1;
      #1;
      check("ms_fix_rdy", 32'(bus.in_ready), 32'b1000);
      tick(); chk_out("ms_ch3", chd[3], 2'd3);

      // Fixed select sel=2 with all valid.
      chd[2] = 16'hBEEF;
      bus.sel = 2'd2;
      put_data();
      check("fix_rdy", 32'(bus.in_ready), 32'b0100);
      tick(); chk_out("fix_beef", 16'hBEEF, 2'd2);
      tick(); chk_out("fix_again", 16'hBEEF, 2'd2);

      // Back to round-robin: ptr still 2 from before fixed mode.
      bus.mode = 1'b1;
      #1;
      check("rr_resume_rdy", 32'(bus.in_ready), 32'b0100);
      tick(); chk_out("rr_resume", 16'hBEEF, 2'd2);
      tick(); chk_out("rr_resume3", chd[3], 2'd3);

      // Drain with no requests.
      bus.in_valid = 4'b0000;
      #1;
      check("drain_rdy", 32'(bus.in_ready), 32'b0000);
      tick();
      check("drain_valid", 32'(bus.out_valid), 32'd0);

      // Reset mid-stream: output cleared immediately, ptr back to 0.
      bus.in_valid = 4'b1111;
      tick(); chk_out("pre_rst", chd[0], 2'd0);
      rst_n = 1'b0;
      #1;
      check("mrst_valid", 32'(bus.out_valid), 32'd0);
      check("mrst_data",  32'(bus.out_data),  32'h0);
      rst_n = 1'b1;
      #1;
      check("mrst_rdy", 32'(bus.in_ready), 32'b0001);
      tick(); chk_out("mrst_first", chd[0], 2'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
